// File: rtl/fpsynth_audio_pkg.sv
// Shared audio types and constants for the synth output path.
package fpsynth_audio_pkg;
  localparam int SAMPLE_W = 16;

  typedef logic signed [SAMPLE_W-1:0] sample_t;

  localparam int I2S_BCLK_HALF_DEFAULT = 8;
  localparam int I2S_SLOT_BITS_DEFAULT = 32;

  localparam sample_t SAMPLE_MAX = 16'h7fff;
  localparam sample_t SAMPLE_MIN = 16'h8000;
endpackage

// File: rtl/i2s_clkgen.sv
// I2S timing: clk48m divider, bclk, bit position and the strobes that step
// the data path on bclk falling edges.
module i2s_clkgen #(
  parameter int BCLK_HALF = 8,
  parameter int SLOT_BITS = 32,
  localparam int DIV_W = $clog2(BCLK_HALF),
  localparam int POS_W = $clog2(2*SLOT_BITS)
) (
  input  logic             clk48m,
  input  logic             rst_n,
  output logic             bclk,
  output logic [POS_W-1:0] pos_nxt,
  output logic             bclk_fall,
  output logic             frame_start
);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BCLK_HALF-1);
  localparam logic [POS_W-1:0] POS_LAST = POS_W'(2*SLOT_BITS-1);

  logic [DIV_W-1:0] div;
  logic [POS_W-1:0] pos;
  logic             div_wrap;

  always_comb begin
    div_wrap    = (div == DIV_LAST);
    bclk_fall   = div_wrap & bclk;
    frame_start = bclk_fall & (pos == POS_LAST);
    pos_nxt     = (pos == POS_LAST) ? '0 : pos + 1'b1;
  end

  always_ff @(posedge clk48m) begin
    if (!rst_n) begin
      div  <= '0;
      bclk <= 1'b0;
      pos  <= POS_LAST;
    end else begin
      div <= div_wrap ? '0 : div + 1'b1;
      if (div_wrap) bclk <= ~bclk;
      if (bclk_fall) pos <= pos_nxt;
    end
  end
endmodule

// File: rtl/i2s_tx.sv
// Philips I2S transmitter: one-entry sample buffer, per-channel shift
// registers and lrck/sdata generation, all in the clk48m domain.
module i2s_tx
  import fpsynth_audio_pkg::*;
#(
  parameter int DATA_W    = SAMPLE_W,
  parameter int BCLK_HALF = I2S_BCLK_HALF_DEFAULT,
  parameter int SLOT_BITS = I2S_SLOT_BITS_DEFAULT
) (
  input  logic              clk48m,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] left,
  input  logic [DATA_W-1:0] right,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              bclk,
  output logic              lrck,
  output logic              sdata,
  output logic              frame_strobe,
  output logic              underrun
);
  localparam int POS_W = $clog2(2*SLOT_BITS);
  localparam logic [POS_W-1:0] L_LO   = POS_W'(1);
  localparam logic [POS_W-1:0] L_HI   = POS_W'(DATA_W);
  localparam logic [POS_W-1:0] R_LO   = POS_W'(SLOT_BITS+1);
  localparam logic [POS_W-1:0] R_HI   = POS_W'(SLOT_BITS+DATA_W);
  localparam logic [POS_W-1:0] SLOT_P = POS_W'(SLOT_BITS);

  logic [POS_W-1:0]  pos_nxt;
  logic              bclk_fall, frame_start;
  logic              full, accept, in_l, in_r;
  logic [DATA_W-1:0] hold_l, hold_r, frm_l, frm_r, sh_l, sh_r;

  i2s_clkgen #(.BCLK_HALF(BCLK_HALF), .SLOT_BITS(SLOT_BITS)) u_clkgen (
    .clk48m      (clk48m),
    .rst_n       (rst_n),
    .bclk        (bclk),
    .pos_nxt     (pos_nxt),
    .bclk_fall   (bclk_fall),
    .frame_start (frame_start)
  );

  assign in_ready = rst_n & ~full;
  assign accept   = in_valid & in_ready;

  // Windows are judged on the position being entered, since outputs are
  // registered on the same edge that advances it.
  always_comb begin
    in_l = (pos_nxt >= L_LO) && (pos_nxt <= L_HI);
    in_r = (pos_nxt >= R_LO) && (pos_nxt <= R_HI);
  end

  always_ff @(posedge clk48m) begin
    if (!rst_n) begin
      full         <= 1'b0;
      hold_l       <= '0;
      hold_r       <= '0;
      frm_l        <= '0;
      frm_r        <= '0;
      sh_l         <= '0;
      sh_r         <= '0;
      lrck         <= 1'b1;
      sdata        <= 1'b0;
      frame_strobe <= 1'b0;
      underrun     <= 1'b0;
    end else begin
      frame_strobe <= 1'b0;
      underrun     <= 1'b0;
      if (accept) begin
        full   <= 1'b1;
        hold_l <= left;
        hold_r <= right;
      end
      if (frame_start) begin
        frame_strobe <= 1'b1;
        if (full) begin
          full  <= 1'b0;
          frm_l <= hold_l;
          frm_r <= hold_r;
          sh_l  <= hold_l;
          sh_r  <= hold_r;
        end else begin
          // Starved: replay the last frame rather than dropping to silence.
          underrun <= 1'b1;
          sh_l     <= frm_l;
          sh_r     <= frm_r;
        end
      end else if (bclk_fall) begin
        if (in_l) sh_l <= {sh_l[DATA_W-2:0], 1'b0};
        if (in_r) sh_r <= {sh_r[DATA_W-2:0], 1'b0};
      end
      if (bclk_fall) begin
        lrck  <= (pos_nxt >= SLOT_P);
        sdata <= in_l ? sh_l[DATA_W-1] : (in_r ? sh_r[DATA_W-1] : 1'b0);
      end
    end
  end
endmodule

// File: tb/tb_i2s_tx.sv
// Scoreboard bench for i2s_tx: accepted pairs are queued by the driver, and a
// monitor derives every output from cycle arithmetic since reset release.
module tb_i2s_tx;
  localparam int DW   = 16;
  localparam int BH   = 8;
  localparam int SB   = 32;
  localparam int HALF = 2*BH;
  localparam int FR   = 4*SB*BH;

  logic        clk48m = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] left = '0, right = '0;
  logic        in_valid = 1'b0;
  logic        in_ready, bclk, lrck, sdata, frame_strobe, underrun;

  i2s_tx #(.DATA_W(DW), .BCLK_HALF(BH), .SLOT_BITS(SB)) dut (
    .clk48m       (clk48m),
    .rst_n        (rst_n),
    .left         (left),
    .right        (right),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .bclk         (bclk),
    .lrck         (lrck),
    .sdata        (sdata),
    .frame_strobe (frame_strobe),
    .underrun     (underrun)
  );

  always #10 clk48m = ~clk48m;

  int cyc = 0;
  always @(posedge clk48m) cyc <= cyc + 1;

  typedef struct { logic [15:0] l; logic [15:0] r; int acc; } ent_t;
  ent_t q[$];

  int checks = 0, errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor / reference model: position in the frame is pure arithmetic on k,
  // the number of clk48m edges since reset was released.
  int          k = 0, b;
  bit          armed = 0;
  logic [15:0] cur_l = '0, cur_r = '0;
  logic        e_strobe, e_under, e_bclk, e_lr, e_sd, e_ready;

  always @(posedge clk48m) begin
    #1;
    if (!rst_n) begin
      armed = 1;
      k     = 0;
      q.delete();
      cur_l = '0;
      cur_r = '0;
      chk("rst_bclk", bclk, 0);
      chk("rst_lrck", lrck, 1);
      chk("rst_sdata", sdata, 0);
      chk("rst_ready", in_ready, 0);
      chk("rst_strobe", frame_strobe, 0);
      chk("rst_underrun", underrun, 0);
    end else if (armed) begin
      k++;
      e_strobe = (k >= HALF) && (((k - HALF) % FR) == 0);
      e_under  = 1'b0;
      if (e_strobe) begin
        if (q.size() > 0 && q[0].acc < cyc) begin
          cur_l = q[0].l;
          cur_r = q[0].r;
          void'(q.pop_front());
        end else begin
          e_under = 1'b1;
        end
      end
      e_bclk = ((k / BH) % 2) == 1;
      if (k < HALF) begin
        e_lr = 1'b1;
        e_sd = 1'b0;
      end else begin
        b    = ((k - HALF) / HALF) % (2*SB);
        e_lr = (b >= SB);
        if (b >= 1 && b <= DW)                e_sd = cur_l[DW-b];
        else if (b >= SB+1 && b <= SB+DW)     e_sd = cur_r[SB+DW-b];
        else                                  e_sd = 1'b0;
      end
      e_ready = !(q.size() > 0 && q[0].acc <= cyc);
      chk("bclk", bclk, e_bclk);
      chk("lrck", lrck, e_lr);
      chk("sdata", sdata, e_sd);
      chk("frame_strobe", frame_strobe, e_strobe);
      chk("underrun", underrun, e_under);
      chk("in_ready", in_ready, e_ready);
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk48m);
  endtask

  task automatic do_reset(input int n);
    @(negedge clk48m);
    rst_n    = 1'b0;
    in_valid = 1'b0;
    repeat (n) @(negedge clk48m);
    rst_n = 1'b1;
  endtask

  // Offers a pair until taken; the expected entry is tagged with the edge
  // that will capture it. Inputs are scrambled afterwards unless keep is set.
  task automatic send(input logic [15:0] l, input logic [15:0] r, input bit keep);
    left     = l;
    right    = r;
    in_valid = 1'b1;
    for (int t = 0; t < 4000; t++) begin
      #1;
      if (in_ready === 1'b1) begin
        q.push_back('{l, r, cyc + 1});
        @(negedge clk48m);
        if (!keep) begin
          in_valid = 1'b0;
          left     = 16'($urandom);
          right    = 16'($urandom);
        end
        return;
      end
      @(negedge clk48m);
    end
    checks++;
    errors++;
    $display("FAIL send_timeout: in_ready stayed 0 for pair %h/%h", l, r);
    in_valid = 1'b0;
  endtask

  task automatic wait_strobe();
    for (int t = 0; t < 2000; t++) begin
      @(negedge clk48m);
      if (frame_strobe === 1'b1) return;
    end
    checks++;
    errors++;
    $display("FAIL strobe_timeout: no frame_strobe within 2000 cycles");
  endtask

  initial begin
    repeat (90000) @(posedge clk48m);
    $display("FAIL watchdog: simulation exceeded cycle budget");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] l, r;
    // idle after reset: zero frame with underrun
    do_reset(3);
    idle(1100);
    // extreme levels accepted before the first frame
    do_reset(2);
    send(16'h7fff, 16'h8000, 0);
    idle(2200);
    // back-to-back stream with in_valid held high
    send(16'ha5a5, 16'h5a5a, 1);
    send(16'h1234, 16'hfedc, 0);
    idle(2200);
    // single pair then starvation
    send(16'h8000, 16'h7fff, 0);
    idle(3200);
    // one-cycle reset in the left slot with a pair buffered
    wait_strobe();
    send(16'h1111, 16'h2222, 0);
    idle(127);
    do_reset(1);
    idle(1100);
    // random traffic with random gaps
    for (int i = 0; i < 12; i++) begin
      idle($urandom_range(0, 1400));
      case ($urandom_range(0, 3))
        0:       begin l = 16'h7fff; r = 16'h8000; end
        1:       begin l = 16'h8000; r = 16'h7fff; end
        default: begin l = 16'($urandom); r = 16'($urandom); end
      endcase
      send(l, r, 0);
    end
    idle(2100);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
